// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, zero constant and FSM state type for the operand fetch block
package rf_pkg;
    localparam int REG_SIZE   = 32;
    localparam int INDEX_SIZE = 5;
    localparam logic [REG_SIZE-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        VALID   = 2'd2
    } state_t;
endpackage

// File: rtl/rf_operand_fetch_if.sv
// rtl/rf_operand_fetch_if.sv - request, writeback, register-file and operand signals of rf_operand_fetch
interface rf_operand_fetch_if import rf_pkg::*; ();
    logic                  req_valid;
    logic                  req_ready;
    logic [INDEX_SIZE-1:0] req_rs;
    logic [INDEX_SIZE-1:0] req_rt;

    logic                  wb_valid;
    logic [INDEX_SIZE-1:0] wb_addr;
    logic [REG_SIZE-1:0]   wb_data;

    logic                  rf_read_enabled;
    logic [INDEX_SIZE-1:0] rf_read_addr_s;
    logic [INDEX_SIZE-1:0] rf_read_addr_t;
    logic                  rf_write_enabled;
    logic [INDEX_SIZE-1:0] rf_write_addr;
    logic [REG_SIZE-1:0]   rf_write_data;
    logic [REG_SIZE-1:0]   rf_outA;
    logic [REG_SIZE-1:0]   rf_outB;

    logic                  op_valid;
    logic                  op_ready;
    logic [REG_SIZE-1:0]   op_a;
    logic [REG_SIZE-1:0]   op_b;

    modport master (
        output req_valid, req_rs, req_rt, wb_valid, wb_addr, wb_data, rf_outA, rf_outB, op_ready,
        input  req_ready, rf_read_enabled, rf_read_addr_s, rf_read_addr_t,
               rf_write_enabled, rf_write_addr, rf_write_data, op_valid, op_a, op_b
    );

    modport slave (
        input  req_valid, req_rs, req_rt, wb_valid, wb_addr, wb_data, rf_outA, rf_outB, op_ready,
        output req_ready, rf_read_enabled, rf_read_addr_s, rf_read_addr_t,
               rf_write_enabled, rf_write_addr, rf_write_data, op_valid, op_a, op_b
    );
endinterface

// File: rtl/rf_bypass_sel.sv
// rtl/rf_bypass_sel.sv - per-operand writeback compare and value select (index 0 always reads zero)
module rf_bypass_sel import rf_pkg::*; (
    input  logic [INDEX_SIZE-1:0] i_index,
    input  logic                  i_wb_valid,
    input  logic [INDEX_SIZE-1:0] i_wb_addr,
    input  logic [REG_SIZE-1:0]   i_wb_data,
    input  logic [REG_SIZE-1:0]   i_rf_value,
    output logic                  o_hit,
    output logic [REG_SIZE-1:0]   o_value
);
    assign o_hit   = i_wb_valid && (i_wb_addr == i_index) && (i_index != '0);
    assign o_value = (i_index == '0) ? ZERO : (o_hit ? i_wb_data : i_rf_value);
endmodule

// File: rtl/rf_operand_fetch.sv
// rtl/rf_operand_fetch.sv - operand fetch from a registered-read register file with writeback bypass
// Define RF_OPERAND_TRACK_EN to keep held operands updated by later writebacks.
module rf_operand_fetch import rf_pkg::*; (
    input logic         clock,
    input logic         reset_n,
    rf_operand_fetch_if.slave bus
);
    state_t                r_state;
    logic                  r_op_valid;
    logic [INDEX_SIZE-1:0] r_rs;
    logic [INDEX_SIZE-1:0] r_rt;
    logic                  r_byp_a;
    logic                  r_byp_b;
    logic [REG_SIZE-1:0]   r_byp_data;
    logic [REG_SIZE-1:0]   r_op_a;
    logic [REG_SIZE-1:0]   r_op_b;

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_wb_valid;
    logic [INDEX_SIZE-1:0] w_idx_a;
    logic [INDEX_SIZE-1:0] w_idx_b;
    logic [REG_SIZE-1:0]   w_rf_a;
    logic [REG_SIZE-1:0]   w_rf_b;
    logic                  w_hit_a;
    logic                  w_hit_b;
    logic [REG_SIZE-1:0]   w_val_a;
    logic [REG_SIZE-1:0]   w_val_b;

    assign w_req_ready = reset_n && ((r_state == IDLE) || ((r_state == VALID) && bus.op_ready));
    assign w_accept    = bus.req_valid && w_req_ready;

    assign bus.req_ready        = w_req_ready;
    assign bus.rf_read_enabled  = w_accept;
    assign bus.rf_read_addr_s   = bus.req_rs;
    assign bus.rf_read_addr_t   = bus.req_rt;
    assign bus.rf_write_enabled = bus.wb_valid;
    assign bus.rf_write_addr    = bus.wb_addr;
    assign bus.rf_write_data    = bus.wb_data;
    assign bus.op_valid         = r_op_valid;
    assign bus.op_a             = r_op_a;
    assign bus.op_b             = r_op_b;

    // The selectors compare against the incoming index at accept, otherwise against the held one.
    assign w_idx_a = w_accept ? bus.req_rs : r_rs;
    assign w_idx_b = w_accept ? bus.req_rt : r_rt;
`ifdef RF_OPERAND_TRACK_EN
    assign w_wb_valid = bus.wb_valid;
`else
    assign w_wb_valid = bus.wb_valid && w_accept;
`endif
    assign w_rf_a = (r_state == CAPTURE) ? (r_byp_a ? r_byp_data : bus.rf_outA) : r_op_a;
    assign w_rf_b = (r_state == CAPTURE) ? (r_byp_b ? r_byp_data : bus.rf_outB) : r_op_b;

    rf_bypass_sel u_sel_a (
        .i_index    (w_idx_a),
        .i_wb_valid (w_wb_valid),
        .i_wb_addr  (bus.wb_addr),
        .i_wb_data  (bus.wb_data),
        .i_rf_value (w_rf_a),
        .o_hit      (w_hit_a),
        .o_value    (w_val_a)
    );

    rf_bypass_sel u_sel_b (
        .i_index    (w_idx_b),
        .i_wb_valid (w_wb_valid),
        .i_wb_addr  (bus.wb_addr),
        .i_wb_data  (bus.wb_data),
        .i_rf_value (w_rf_b),
        .o_hit      (w_hit_b),
        .o_value    (w_val_b)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_op_valid <= 1'b0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_byp_a    <= 1'b0;
            r_byp_b    <= 1'b0;
            r_byp_data <= ZERO;
            r_op_a     <= ZERO;
            r_op_b     <= ZERO;
        end else begin
            if (w_accept) begin
                r_rs       <= bus.req_rs;
                r_rt       <= bus.req_rt;
                r_byp_a    <= w_hit_a;
                r_byp_b    <= w_hit_b;
                r_byp_data <= bus.wb_data;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_op_a     <= w_val_a;
                    r_op_b     <= w_val_b;
                    r_op_valid <= 1'b1;
                    r_state    <= VALID;
                end
                VALID: begin
                    if (bus.op_ready) begin
                        r_op_valid <= 1'b0;
                        r_state    <= w_accept ? CAPTURE : IDLE;
                    end else begin
                        // Holds unless writeback tracking is built in.
                        r_op_a <= w_val_a;
                        r_op_b <= w_val_b;
                    end
                end
                default: begin
                    r_op_valid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rf_operand_fetch.sv
// tb/tb_rf_operand_fetch.sv - self-checking bench for rf_operand_fetch with a registered-read register file model
module tb_rf_operand_fetch;
    import rf_pkg::*;

`ifdef RF_OPERAND_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n;
    logic preload;
    int   checks = 0;
    int   errors = 0;

    rf_operand_fetch_if bus ();

    rf_operand_fetch dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Environment register file: registered read, read-before-write, index 0 writable.
    logic [31:0] rf_mem [32];
    logic [31:0] rf_out_a;
    logic [31:0] rf_out_b;
    // Architectural model: what each index should read as (index 0 is always zero).
    logic [31:0] model_regs [32];

    assign bus.rf_outA = rf_out_a;
    assign bus.rf_outB = rf_out_b;

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) begin
                rf_mem[i]     <= 32'hC0DE_0000 | 32'(i);
                model_regs[i] <= (i == 0) ? 32'h0 : (32'hC0DE_0000 | 32'(i));
            end
        end
        if (bus.rf_read_enabled) begin
            rf_out_a <= rf_mem[bus.rf_read_addr_s];
            rf_out_b <= rf_mem[bus.rf_read_addr_t];
        end
        if (bus.rf_write_enabled) rf_mem[bus.rf_write_addr] <= bus.rf_write_data;
        if (bus.wb_valid && bus.wb_addr != 5'd0) model_regs[bus.wb_addr] <= bus.wb_data;
    end

    function automatic logic [31:0] cur(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : model_regs[idx];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; preload = 1'b1;
        bus.req_valid = 1'b1; bus.req_rs = 5'd3; bus.req_rt = 5'd4;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h5A5A_0009;
        tick(); tick();
        checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got %0b exp 0", bus.op_valid); end
        checks++; if (bus.op_a !== 32'h0) begin errors++; $display("FAIL reset_op_a got %h exp 0", bus.op_a); end
        checks++; if (bus.op_b !== 32'h0) begin errors++; $display("FAIL reset_op_b got %h exp 0", bus.op_b); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %0b exp 0", bus.req_ready); end
        checks++; if (bus.rf_read_enabled !== 1'b0) begin errors++; $display("FAIL reset_read_en got %0b exp 0", bus.rf_read_enabled); end
        checks++; if (bus.rf_write_enabled !== 1'b1 || bus.rf_write_addr !== 5'd9 || bus.rf_write_data !== 32'h5A5A_0009) begin
            errors++; $display("FAIL reset_wb_pass got %0b/%0d/%h exp 1/9/5a5a0009", bus.rf_write_enabled, bus.rf_write_addr, bus.rf_write_data);
        end
        preload = 1'b0; bus.req_valid = 1'b0; bus.wb_valid = 1'b0; reset_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %0b exp 1", bus.req_ready); end
        tick();
    endtask

    task automatic test_basic();
        bus.op_ready = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
        tick();
        bus.wb_valid = 1'b0;
        bus.req_valid = 1'b1; bus.req_rs = 5'd5; bus.req_rt = 5'd0;
        #1;
        checks++; if (bus.rf_read_enabled !== 1'b1 || bus.rf_read_addr_s !== 5'd5 || bus.rf_read_addr_t !== 5'd0) begin
            errors++; $display("FAIL basic_read_port got %0b/%0d/%0d exp 1/5/0", bus.rf_read_enabled, bus.rf_read_addr_s, bus.rf_read_addr_t);
        end
        tick();
        bus.req_valid = 1'b0;
        #1;
        checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b exp 0", bus.op_valid); end
        tick();
        checks++; if (bus.op_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %0b exp 1", bus.op_valid); end
        checks++; if (bus.op_a !== 32'h1234) begin errors++; $display("FAIL basic_op_a got %h exp 00001234", bus.op_a); end
        checks++; if (bus.op_b !== 32'h0) begin errors++; $display("FAIL basic_op_b_zero got %h exp 0", bus.op_b); end
        tick();
        checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed got %0b exp 0", bus.op_valid); end
    endtask

    task automatic test_bypass();
        bus.req_valid = 1'b1; bus.req_rs = 5'd7; bus.req_rt = 5'd5;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'hDEAD_BEEF;
        tick();
        bus.req_valid = 1'b0; bus.wb_valid = 1'b0;
        tick();
        checks++; if (bus.op_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_op_a got %h exp deadbeef", bus.op_a); end
        checks++; if (bus.op_b !== 32'h1234) begin errors++; $display("FAIL bypass_op_b got %h exp 00001234", bus.op_b); end
        tick();
        bus.req_valid = 1'b1; bus.req_rs = 5'd0; bus.req_rt = 5'd0;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
        tick();
        bus.req_valid = 1'b0; bus.wb_valid = 1'b0;
        tick();
        checks++; if (bus.op_valid !== 1'b1 || bus.op_a !== 32'h0 || bus.op_b !== 32'h0) begin
            errors++; $display("FAIL bypass_zero got %0b/%h/%h exp 1/0/0", bus.op_valid, bus.op_a, bus.op_b);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bus.op_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_rs = 5'd5; bus.req_rt = 5'd7;
        tick();
        bus.req_rs = 5'd7; bus.req_rt = 5'd5;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.op_valid !== 1'b1 || bus.op_a !== 32'h1234 || bus.op_b !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL stall_hold cyc %0d got %0b/%h/%h exp 1/00001234/deadbeef", i, bus.op_valid, bus.op_a, bus.op_b);
            end
            checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready cyc %0d got %0b exp 0", i, bus.req_ready); end
            tick();
        end
        bus.op_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1 || bus.rf_read_enabled !== 1'b1) begin
            errors++; $display("FAIL release_accept got %0b/%0b exp 1/1", bus.req_ready, bus.rf_read_enabled);
        end
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got %0b exp 0", bus.op_valid); end
        tick();
        checks++; if (bus.op_valid !== 1'b1 || bus.op_a !== 32'hDEAD_BEEF || bus.op_b !== 32'h1234) begin
            errors++; $display("FAIL b2b_second got %0b/%h/%h exp 1/deadbeef/00001234", bus.op_valid, bus.op_a, bus.op_b);
        end
        tick();
    endtask

    task automatic test_track();
        bus.op_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_rs = 5'd5; bus.req_rt = 5'd0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        checks++; if (bus.op_a !== 32'h1234) begin errors++; $display("FAIL track_before got %h exp 00001234", bus.op_a); end
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hAAAA;
        tick();
        bus.wb_data = 32'hBBBB;
        tick();
        bus.wb_addr = 5'd0; bus.wb_data = 32'h1;
        tick();
        bus.wb_valid = 1'b0;
        checks++; if (bus.op_a !== (TRACK ? 32'hBBBB : 32'h1234)) begin
            errors++; $display("FAIL track_op_a got %h exp %h", bus.op_a, TRACK ? 32'hBBBB : 32'h1234);
        end
        checks++; if (bus.op_b !== 32'h0) begin errors++; $display("FAIL track_zero_b got %h exp 0", bus.op_b); end
        bus.op_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_inflight();
        bus.op_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_rs = 5'd5; bus.req_rt = 5'd7;
        tick();
        bus.req_valid = 1'b0; reset_n = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h33;
        #1;
        checks++; if (bus.rf_write_enabled !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL inflight_reset_ports got %0b/%0b exp 1/0", bus.rf_write_enabled, bus.req_ready);
        end
        tick();
        reset_n = 1'b1; bus.wb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL inflight_valid cyc %0d got %0b exp 0", i, bus.op_valid); end
            tick();
        end
        checks++; if (bus.op_a !== 32'h0 || bus.op_b !== 32'h0) begin
            errors++; $display("FAIL inflight_ops got %h/%h exp 0/0", bus.op_a, bus.op_b);
        end
    endtask

    task automatic test_random();
        bit          has_op = 1'b0;
        int          acc_k = 0;
        logic [4:0]  m_rs = '0, m_rt = '0;
        logic [31:0] snap_a = '0, snap_b = '0;
        for (int k = 0; k < 400; k++) begin
            bit visible, exp_ready, accept_now, consume;
            logic [31:0] exp_a, exp_b;
            bus.req_valid = ($urandom_range(2) != 0);
            bus.req_rs    = 5'($urandom_range(31));
            bus.req_rt    = 5'($urandom_range(31));
            bus.op_ready  = ($urandom_range(3) != 0);
            bus.wb_valid  = ($urandom_range(1) != 0);
            bus.wb_data   = $urandom;
            case ($urandom_range(3))
                0:       bus.wb_addr = bus.req_rs;
                1:       bus.wb_addr = bus.req_rt;
                2:       bus.wb_addr = m_rs;
                default: bus.wb_addr = 5'($urandom_range(31));
            endcase
            #1;
            visible   = has_op && (k >= acc_k + 2);
            exp_ready = !has_op || (visible && bus.op_ready);
            checks++; if (bus.op_valid !== visible) begin errors++; $display("FAIL rand_op_valid k %0d got %0b exp %0b", k, bus.op_valid, visible); end
            checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rand_req_ready k %0d got %0b exp %0b", k, bus.req_ready, exp_ready); end
            if (visible) begin
                exp_a = TRACK ? cur(m_rs) : snap_a;
                exp_b = TRACK ? cur(m_rt) : snap_b;
                checks++; if (bus.op_a !== exp_a || bus.op_b !== exp_b) begin
                    errors++; $display("FAIL rand_ops k %0d rs %0d rt %0d got %h/%h exp %h/%h", k, m_rs, m_rt, bus.op_a, bus.op_b, exp_a, exp_b);
                end
            end
            accept_now = bus.req_valid && exp_ready;
            consume    = visible && bus.op_ready;
            if (accept_now) begin m_rs = bus.req_rs; m_rt = bus.req_rt; end
            tick();
            if (consume) has_op = 1'b0;
            if (accept_now) begin
                has_op = 1'b1; acc_k = k;
                snap_a = cur(m_rs); snap_b = cur(m_rt);
            end
        end
        bus.req_valid = 1'b0; bus.wb_valid = 1'b0; bus.op_ready = 1'b1;
        tick(); tick(); tick();
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_rs = '0; bus.req_rt = '0;
        bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.op_ready = 1'b1;
        reset_n = 1'b0; preload = 1'b1;
        test_reset();
        test_basic();
        test_bypass();
        test_backpressure();
        test_track();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_operand_fetch.md
RF_OPERAND_FETCH -- requirements
Module: rf_operand_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clock  in  1  rising-edge clock; reset_n  in  1  synchronous active-low reset.
REQ-002 The block SHALL have these request-side ports: req_valid  in  1  read request; req_ready  out  1  request accepted; req_rs  in  5  source-s index; req_rt  in  5  source-t index.
REQ-003 The block SHALL have these writeback ports: wb_valid  in  1  write request, always accepted; wb_addr  in  5  destination index; wb_data  in  32  write value.
REQ-004 The block SHALL have these register-file ports: rf_read_enabled  out  1; rf_read_addr_s  out  5; rf_read_addr_t  out  5; rf_write_enabled  out  1; rf_write_addr  out  5; rf_write_data  out  32; rf_outA  in  32; rf_outB  in  32.
REQ-005 The block SHALL have these operand-side ports: op_valid  out  1  operands valid; op_ready  in  1  consumer accepts; op_a  out  32  rs value; op_b  out  32  rt value.

Function
REQ-006 The block SHALL target a register file with a registered read: rf_outA/rf_outB update on the rising edge where rf_read_enabled=1, return pre-write contents on a same-edge write, and hold otherwise.
REQ-007 The FSM SHALL have states IDLE, CAPTURE and VALID; req_ready=1 in IDLE, and in VALID when op_ready=1; otherwise 0.
REQ-008 Accept SHALL mean req_valid&&req_ready at a rising edge; rf_read_enabled SHALL equal req_valid&&req_ready combinationally; rf_read_addr_s=req_rs; rf_read_addr_t=req_rt.
REQ-009 On accept the FSM SHALL go to CAPTURE and latch rs, rt and the per-operand bypass flags/data.
REQ-010 In CAPTURE the block SHALL latch op_a/op_b at the next edge from rf_outA/rf_outB, or from the bypass data when the bypass flag is set, then go to VALID.
REQ-011 Bypass flag for an operand SHALL set at the accept edge iff wb_valid=1, wb_addr equals that index, and the index is nonzero; bypass data SHALL be that edge's wb_data.
REQ-012 Index 0 SHALL yield op value 32'h0 regardless of register-file output or writeback.
REQ-013 op_valid SHALL be 1 exactly in VALID; op_a/op_b SHALL hold stable while op_valid=1 and op_ready=0.
REQ-014 In VALID with op_ready=1: with req_valid=1 go to CAPTURE (new accept); otherwise go to IDLE.
REQ-015 Latency SHALL be 2 edges accept-to-op_valid; peak throughput SHALL be one request per 2 cycles.
REQ-016 rf_write_enabled, rf_write_addr and rf_write_data SHALL be combinational pass-throughs of wb_valid, wb_addr and wb_data in every state.
REQ-017 A writeback and an accept on the same edge to the same nonzero index SHALL return the new wb_data.

Reset
REQ-018 When reset_n=0 at an edge, state SHALL become IDLE, op_valid=0, op_a=op_b=0, bypass flags clear, and any in-flight request SHALL be discarded without op_valid.
REQ-019 During reset, rf_read_enabled SHALL be 0 and req_ready SHALL be 0; writeback pass-through SHALL stay active.

Configuration
REQ-020 Macro RF_OPERAND_TRACK_EN SHALL gate writeback tracking of held operands.
REQ-021 With RF_OPERAND_TRACK_EN defined: any wb_valid to a matching nonzero index at an edge in CAPTURE or VALID SHALL update that operand to wb_data, with the later write winning.
REQ-022 Without RF_OPERAND_TRACK_EN, operands SHALL be a snapshot at the accept edge (REQ-011 bypass only); later writes SHALL not alter op_a/op_b.

Structure
REQ-023 Shared package rf_pkg SHALL hold REG_SIZE=32, INDEX_SIZE=5, the ZERO constant and the FSM state typedef.
REQ-024 Sub-module rf_bypass_sel SHALL do the per-operand compare and select (index, wb_valid/addr/data, rf value -> value), instantiated twice.

Verification
REQ-025 Reg5=32'h1234 preloaded; req rs=5, rt=0; op_ready=1 -> op_valid 2 edges later, op_a=32'h1234, op_b=0.
REQ-026 Accept rs=7 at the same edge as wb 7<-32'hDEAD_BEEF -> op_a=32'hDEAD_BEEF; repeat with wb_addr=0 and rs=0 -> op_a=0.
REQ-027 op_ready=0 for 5 cycles after op_valid -> op_a/op_b stable, req_ready=0; op_ready=1 with req_valid=1 -> next accept the same edge, op_valid again 2 edges later.
REQ-028 TRACK_EN on: in VALID, wb 5<-32'hAAAA then 5<-32'hBBBB -> op_a=32'hBBBB; TRACK_EN off -> op_a unchanged.
REQ-029 reset_n=0 for one edge in CAPTURE -> IDLE, op_valid never asserts, op_a=op_b=0; wb during reset still drives rf_write_enabled=1.
